// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES SubBytes types and constants
package aes_pkg;

    localparam int AES_BYTE_W = 8;
    localparam int AES_NBYTES = 16;

    typedef logic [AES_BYTE_W-1:0] aes_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

endpackage

// File: rtl/sbox_byte.sv
// rtl/sbox_byte.sv - combinational AES forward S-box, one byte
module sbox_byte
    import aes_pkg::*;
(
    input  aes_byte_t plain,
    output aes_byte_t subst
);

    function automatic aes_byte_t xtime(input aes_byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p;
        aes_byte_t s;
        p = 8'h00;
        s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ s;
            end
            s = xtime(s);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic aes_byte_t gf_inv(input aes_byte_t x);
        aes_byte_t x2, x4, x8, x16, x32, x64, x128;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        return gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                      gf_mul(gf_mul(x32, x64), x128));
    endfunction

    function automatic aes_byte_t rotl(input aes_byte_t b, input int k);
        return aes_byte_t'((b << k) | (b >> (8 - k)));
    endfunction

    aes_byte_t inv;

    always_comb begin
        inv   = gf_inv(plain);
        subst = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

endmodule

// File: rtl/aes_subbytes_seq.sv
// rtl/aes_subbytes_seq.sv - sequential SubBytes over a shared S-box (SBOX_DUAL_EN: two lanes)
module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int XLEN   = AES_BYTE_W,
    parameter int NBYTES = AES_NBYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NBYTES*XLEN-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NBYTES*XLEN-1:0]   out_data,
    input  logic                     flush,
    output logic                     busy
);

`ifdef SBOX_DUAL_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    aes_state_e              state_q;
    logic [CW-1:0]           cnt_q;
    logic [NBYTES*XLEN-1:0]  work_q;
    logic [NBYTES*XLEN-1:0]  work_nx;
    logic [NBYTES*XLEN-1:0]  result_q;
    logic [XLEN-1:0]         sb_in  [LANES];
    logic [XLEN-1:0]         sb_out [LANES];
    logic                    last_step;

    for (genvar g = 0; g < LANES; g++) begin : g_sbox
        sbox_byte u_sbox (
            .plain (sb_in[g]),
            .subst (sb_out[g])
        );
    end

    // Bytes are replaced in place in the work copy; out_data only changes on completion.
    always_comb begin
        work_nx = work_q;
        for (int l = 0; l < LANES; l++) begin
            sb_in[l] = work_q[(int'(cnt_q) + l)*XLEN +: XLEN];
            work_nx[(int'(cnt_q) + l)*XLEN +: XLEN] = sb_out[l];
        end
    end

    assign last_step = (cnt_q == CW'(NBYTES - LANES));
    assign out_data  = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            result_q  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q   <= in_data;
                        cnt_q    <= '0;
                        state_q  <= ST_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    work_q <= work_nx;
                    if (last_step) begin
                        result_q  <= work_nx;
                        state_q   <= ST_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(LANES);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
